// File: rtl/latch_sync_edge_pkg.sv
// Shared types and parameter-range limits for the latch synchronizer / edge-event block.
package latch_sync_edge_pkg;

  localparam int unsigned SYNC_MIN   = 2;
  localparam int unsigned SYNC_MAX   = 4;
  localparam int unsigned FILT_MIN   = 1;
  localparam int unsigned FILT_MAX   = 15;
  localparam int unsigned FILT_CNT_W = 4;

  typedef enum logic {
    StIdle,
    StHold
  } ev_state_e;

endpackage

// File: rtl/latch_sync_edge_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the C domain.
module sync_chain
  import latch_sync_edge_pkg::*;
#(
  parameter logic        INIT        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic C,
  input  logic CLR,
  input  logic D,
  output logic S
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : gen_stage_range_err
    $error("sync_chain: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      sync_q <= {SYNC_STAGES{INIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], D};
    end
  end

  assign S = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/latch_sync_edge.sv
// Synchronizes and debounces an asynchronous level, flags its edges and offers each edge
// as a single-entry valid/ready event with a sticky overflow flag for dropped events.
module latch_sync_edge
  import latch_sync_edge_pkg::*;
#(
  parameter logic        INIT        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             D,
  input  logic             CE,
  output logic             Q,
  output logic             RISE,
  output logic             FALL,
  output logic             EV_VLD,
  input  logic             EV_RDY,
  output logic             EV_DIR,
  output logic [CNT_W-1:0] EV_CNT,
  output logic             OVF,
  input  logic             OVF_CLR
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : gen_sync_range_err
    $error("latch_sync_edge: SYNC_STAGES out of range");
  end
  if (FILT_LEN < FILT_MIN || FILT_LEN > FILT_MAX) begin : gen_filt_range_err
    $error("latch_sync_edge: FILT_LEN out of range");
  end
  if (CNT_W < 1) begin : gen_cnt_w_err
    $error("latch_sync_edge: CNT_W must be at least 1");
  end

  logic                  s;
  logic [FILT_CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [FILT_CNT_W:0]   filt_inc;
  logic                  q_q, q_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
  ev_state_e             state_q, state_d;
  logic                  ev_dir_q, ev_dir_d;
  logic [CNT_W-1:0]      ev_cnt_q, ev_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  trans;
  logic                  ev_load;
  logic                  ovf_set;

  sync_chain #(
    .INIT        (INIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .C   (C),
    .CLR (CLR),
    .D   (D),
    .S   (s)
  );

  // Q only follows S after FILT_LEN consecutive enabled cycles of disagreement.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    q_d        = q_q;
    trans      = 1'b0;
    filt_inc   = {1'b0, filt_cnt_q} + 5'd1;
    if (CE) begin
      if (s != q_q) begin
        if (filt_inc == 5'(FILT_LEN)) begin
          q_d        = s;
          filt_cnt_d = '0;
          trans      = 1'b1;
        end else begin
          filt_cnt_d = filt_inc[FILT_CNT_W-1:0];
        end
      end else begin
        filt_cnt_d = '0;
      end
    end
  end

  always_comb begin
    rise_d     = trans & s;
    fall_d     = trans & ~s;
    edge_cnt_d = trans ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
  end

  // Event FSM next state; a transition that meets an unacknowledged event is dropped.
  always_comb begin
    state_d = state_q;
    ev_load = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trans) begin
          state_d = StHold;
          ev_load = 1'b1;
        end
      end
      StHold: begin
        if (EV_RDY) begin
          if (trans) begin
            ev_load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (trans) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ev_dir_d = ev_load ? s : ev_dir_q;
    ev_cnt_d = ev_load ? edge_cnt_d : ev_cnt_q;
    ovf_d    = ovf_set | (ovf_q & ~OVF_CLR);
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      filt_cnt_q <= '0;
      q_q        <= INIT;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      q_q        <= q_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q  <= StIdle;
      ev_dir_q <= 1'b0;
      ev_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ev_dir_q <= ev_dir_d;
      ev_cnt_q <= ev_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    EV_VLD = (state_q == StHold);
  end

  assign Q      = q_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;
  assign EV_DIR = ev_dir_q;
  assign EV_CNT = ev_cnt_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_latch_sync_edge.sv
// Randomized self-checking bench for latch_sync_edge against a behavioural event model.
module tb_latch_sync_edge;

  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic C = 1'b0;
  logic CLR = 1'b1;
  logic D = 1'b0;
  logic CE = 1'b1;
  logic EV_RDY = 1'b0;
  logic OVF_CLR = 1'b0;

  logic       q_a, rise_a, fall_a, vld_a, dir_a, ovf_a;
  logic [7:0] cnt_a;
  logic       q_b, rise_b, fall_b, vld_b, dir_b, ovf_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 C = ~C;

  latch_sync_edge #(
    .INIT        (1'b0),
    .SYNC_STAGES (SYNC),
    .FILT_LEN    (FILT),
    .CNT_W       (8)
  ) dut (
    .C       (C),
    .CLR     (CLR),
    .D       (D),
    .CE      (CE),
    .Q       (q_a),
    .RISE    (rise_a),
    .FALL    (fall_a),
    .EV_VLD  (vld_a),
    .EV_RDY  (EV_RDY),
    .EV_DIR  (dir_a),
    .EV_CNT  (cnt_a),
    .OVF     (ovf_a),
    .OVF_CLR (OVF_CLR)
  );

  latch_sync_edge #(
    .INIT        (1'b0),
    .SYNC_STAGES (SYNC),
    .FILT_LEN    (FILT),
    .CNT_W       (2)
  ) dut_w2 (
    .C       (C),
    .CLR     (CLR),
    .D       (D),
    .CE      (CE),
    .Q       (q_b),
    .RISE    (rise_b),
    .FALL    (fall_b),
    .EV_VLD  (vld_b),
    .EV_RDY  (EV_RDY),
    .EV_DIR  (dir_b),
    .EV_CNT  (cnt_b),
    .OVF     (ovf_b),
    .OVF_CLR (OVF_CLR)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: D delayed SYNC samples, run-length debounce, one-slot mailbox.
  typedef struct packed {
    logic [SYNC-1:0] hist;
    logic            q;
    logic [7:0]      run;
    logic [7:0]      ecnt;
    logic            rise;
    logic            fall;
    logic            pend;
    logic            pdir;
    logic [7:0]      pcnt;
    logic            ovf;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t mstep(input mdl_t cur, input logic d, input logic ce,
                                 input logic rdy, input logic oclr);
    mdl_t n;
    logic s_old;
    logic tr;
    logic drop;
    n      = cur;
    s_old  = cur.hist[SYNC-1];
    n.hist = {cur.hist[SYNC-2:0], d};
    tr     = 1'b0;
    drop   = 1'b0;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (ce) begin
      if (s_old != cur.q) begin
        n.run = cur.run + 8'd1;
        if (int'(n.run) == FILT) begin
          tr    = 1'b1;
          n.q   = s_old;
          n.run = 8'd0;
        end
      end else begin
        n.run = 8'd0;
      end
    end
    if (tr) begin
      n.ecnt = cur.ecnt + 8'd1;
      n.rise = n.q;
      n.fall = ~n.q;
    end
    if (cur.pend && rdy) n.pend = 1'b0;
    if (tr) begin
      if (!n.pend) begin
        n.pend = 1'b1;
        n.pdir = n.q;
        n.pcnt = n.ecnt;
      end else begin
        drop = 1'b1;
      end
    end
    n.ovf = drop ? 1'b1 : (oclr ? 1'b0 : cur.ovf);
    return n;
  endfunction

  always @(posedge C or posedge CLR) begin
    if (CLR) m <= '0;
    else     m <= mstep(m, D, CE, EV_RDY, OVF_CLR);
  end

  always @(negedge C) begin
    chk("q", int'(q_a), int'(m.q));
    chk("rise", int'(rise_a), int'(m.rise));
    chk("fall", int'(fall_a), int'(m.fall));
    chk("ev_vld", int'(vld_a), int'(m.pend));
    chk("ovf", int'(ovf_a), int'(m.ovf));
    chk("w2_ev_vld", int'(vld_b), int'(m.pend));
    chk("w2_ovf", int'(ovf_b), int'(m.ovf));
    if (m.pend) begin
      chk("ev_dir", int'(dir_a), int'(m.pdir));
      chk("ev_cnt", int'(cnt_a), int'(m.pcnt));
      chk("w2_ev_cnt", int'(cnt_b), int'(m.pcnt) % 4);
    end
  end

  // Land 2 time units after the n-th following rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge C);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    int hold;
    seq = '{1, 2, 3, 0, 1};

    tick(3);
    chk("reset_q", int'(q_a), 0);
    chk("reset_vld", int'(vld_a), 0);
    chk("reset_cnt", int'(cnt_a), 0);
    CLR = 1'b0;
    tick(3);

    // First rise from reset: Q, RISE and the event appear SYNC+FILT edges after D moves.
    D = 1'b1;
    tick(SYNC + FILT - 1);
    chk("lat_q_early", int'(q_a), 0);
    tick(1);
    chk("lat_q", int'(q_a), 1);
    chk("lat_rise", int'(rise_a), 1);
    chk("lat_vld", int'(vld_a), 1);
    chk("lat_dir", int'(dir_a), 1);
    chk("lat_cnt", int'(cnt_a), 1);
    tick(1);
    chk("lat_rise_one_cycle", int'(rise_a), 0);

    // Second transition with the event unacknowledged is dropped.
    D = 1'b0;
    tick(SYNC + FILT);
    chk("drop_fall", int'(fall_a), 1);
    chk("drop_cnt_held", int'(cnt_a), 1);
    chk("drop_dir_held", int'(dir_a), 1);
    chk("drop_ovf", int'(ovf_a), 1);
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    chk("ovf_clr", int'(ovf_a), 0);

    // Acknowledge coincident with a new transition reloads the slot.
    D = 1'b1;
    tick(SYNC + FILT - 1);
    EV_RDY = 1'b1;
    tick(1);
    chk("reload_vld", int'(vld_a), 1);
    chk("reload_cnt", int'(cnt_a), 3);
    chk("reload_dir", int'(dir_a), 1);
    chk("reload_ovf", int'(ovf_a), 0);
    tick(1);
    chk("ack_vld", int'(vld_a), 0);
    EV_RDY = 1'b0;

    // Three-cycle low glitch is rejected.
    D = 1'b0;
    tick(3);
    D = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_q", int'(q_a), 1);
      chk("glitch_fall", int'(fall_a), 0);
      chk("glitch_vld", int'(vld_a), 0);
    end

    // Real fall: counter shows the glitch did not count.
    D = 1'b0;
    tick(SYNC + FILT);
    chk("post_glitch_cnt", int'(cnt_a), 4);
    chk("post_glitch_vld", int'(vld_a), 1);

    // Reset mid-event with D high.
    D = 1'b1;
    tick(2);
    CLR = 1'b1;
    #1;
    chk("clr_q", int'(q_a), 0);
    chk("clr_vld", int'(vld_a), 0);
    chk("clr_cnt", int'(cnt_a), 0);
    chk("clr_dir", int'(dir_a), 0);
    chk("clr_ovf", int'(ovf_a), 0);
    chk("clr_rise_fall", int'(rise_a) + int'(fall_a), 0);
    tick(1);
    CLR = 1'b0;
    EV_RDY = 1'b1;
    tick(SYNC + FILT - 1);
    chk("rel_q_early", int'(q_a), 0);
    chk("rel_no_pulse", int'(rise_a), 0);
    tick(1);
    chk("rel_q", int'(q_a), 1);
    chk("rel_rise", int'(rise_a), 1);
    chk("w2_seq0", int'(cnt_b), seq[0]);

    // Narrow counter wraps.
    for (int i = 1; i < 5; i++) begin
      D = ~D;
      tick(SYNC + FILT);
      chk("w2_seq", int'(cnt_b), seq[i]);
      chk("w2_seq_vld", int'(vld_b), 1);
    end
    EV_RDY = 1'b0;

    // Random phase.
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold == 0) begin
        D = $urandom_range(1, 0);
        hold = (($urandom_range(3, 0)) == 0) ? $urandom_range(3, 1) : $urandom_range(12, 4);
      end
      hold--;
      CE      = ($urandom_range(9, 0) != 0);
      EV_RDY  = ($urandom_range(2, 0) == 0);
      OVF_CLR = ($urandom_range(19, 0) == 0);
      CLR     = ($urandom_range(299, 0) == 0);
      tick(1);
    end
    CLR = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_sync_edge.md
LATCH_SYNC_EDGE -- requirements
Module: latch_sync_edge

Interface
REQ-001 SHALL have parameter INIT, default 1'b0: reset and initial value of the synchronizer chain and Q.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: synchronizer flop count.
REQ-003 SHALL have parameter FILT_LEN, default 4, legal range 1..15: consecutive stable cycles required before Q changes.
REQ-004 SHALL have parameter CNT_W, default 8: width of the edge counter.
REQ-005 SHALL have port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port CLR, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port D, input, 1 bit: level asynchronous to C, e.g. a latch Q output.
REQ-008 SHALL have port CE, input, 1 bit: clock enable for filter, counter and event capture.
REQ-009 SHALL have port Q, output, 1 bit: filtered, synchronized level.
REQ-010 SHALL have ports RISE and FALL, outputs, 1 bit each: one-cycle pulses on a Q transition.
REQ-011 SHALL have ports EV_VLD (output), EV_RDY (input), EV_DIR (output, 1=rise) and EV_CNT (output, CNT_W bits): single-entry event handshake.
REQ-012 SHALL have ports OVF (output, 1 bit, sticky dropped-event flag) and OVF_CLR (input, 1 bit).

Function
REQ-013 SHALL pass D through SYNC_STAGES flops clocked by C, unconditionally (CE-independent); S is the last stage.
REQ-014 Filter, CE=1: S!=Q increments stable counter; S==Q clears it; counter reaching FILT_LEN loads Q<=S and clears it.
REQ-015 CE=0 SHALL freeze stable counter, Q, edge counter and event capture; handshake and OVF_CLR stay active.
REQ-016 Latency: D stable from cycle 0 changes Q at clock edge SYNC_STAGES+FILT_LEN; glitches shorter than FILT_LEN cycles at S are rejected.
REQ-017 RISE (FALL) SHALL be high for exactly the cycle in which Q has just gone 0->1 (1->0), registered alongside Q.
REQ-018 Edge counter SHALL increment on every Q transition, wrapping modulo 2^CNT_W.
REQ-019 Event FSM states IDLE, HOLD; EV_VLD=1 iff HOLD.
REQ-020 IDLE + Q transition -> HOLD, EV_DIR=direction, EV_CNT=post-increment counter value.
REQ-021 HOLD + EV_RDY=1, no transition -> IDLE.
REQ-022 HOLD + EV_RDY=1 + simultaneous transition -> stay HOLD, reload EV_DIR/EV_CNT with new event; no drop.
REQ-023 HOLD + EV_RDY=0 + transition -> EV_DIR/EV_CNT held stable, event dropped, OVF<=1.
REQ-024 OVF_CLR=1 clears OVF; simultaneous set and clear -> set wins.
REQ-025 EV_DIR/EV_CNT SHALL remain stable while EV_VLD=1 and EV_RDY=0.

Reset
REQ-026 CLR=1 SHALL asynchronously force: sync chain=INIT, Q=INIT, stable counter=0, edge counter=0, RISE=FALL=0, FSM=IDLE, EV_VLD=0, EV_DIR=0, EV_CNT=0, OVF=0.
REQ-027 Reset mid-event SHALL discard the held event; no RISE/FALL pulse on reset release even if D!=INIT (the transition appears only via the normal filter path).
REQ-028 Power-up (no CLR) state SHALL equal reset state.

Structure
REQ-029 Shared package SHALL hold event state enum (IDLE, HOLD) and parameter-range constants (SYNC_MIN=2, SYNC_MAX=4, FILT_MAX=15).
REQ-030 Synchronizer SHALL be sub-module sync_chain (parameters INIT, SYNC_STAGES; ports C, CLR, D, S).
REQ-031 Out-of-range parameters SHALL produce an elaboration error.

Verification
REQ-032 Defaults, D 0->1 held -> Q=1 and RISE pulse at edge 6, EV_VLD=1, EV_DIR=1, EV_CNT=1.
REQ-033 D 3-cycle high glitch at S (FILT_LEN=4) -> Q, RISE, EV_VLD unchanged; counter stays 0.
REQ-034 EV_RDY=0, two transitions -> EV_CNT=1 held, OVF=1; OVF_CLR pulse -> OVF=0.
REQ-035 EV_RDY=1 coincident with a new transition -> EV_VLD stays 1, EV_CNT advances to next value, OVF=0.
REQ-036 CLR pulsed while HOLD, D=1, INIT=0 -> all outputs 0 immediately; Q=1 again SYNC_STAGES+FILT_LEN cycles after release.
REQ-037 CNT_W=2, five transitions with EV_RDY=1 -> EV_CNT sequence 1,2,3,0,1.
